// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller sitting in the M stage.
// Holds SR/Cause/EPC/PRId, raises req, serves MFC0/MTC0 and the ERET target.
module cp0_unit #(
   parameter logic [31:0] PRID_VAL = 32'h2022_0714,
   parameter logic [31:0] HANDLER  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic [4:0]  exc_in,
   input  logic        slot_in,
   input  logic        eret_in,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [5:0]  hwint,
   output logic [31:0] rdata,
   output logic [31:0] epc_out,
   output logic        req
);

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_code;
   logic [29:0] r_epc;

   logic        w_int_req;
   logic        w_exc_req;
   logic        w_req;
   logic [4:0]  w_code;
   logic [29:0] w_epc_next;
   logic [31:0] w_sr;
   logic [31:0] w_cause;
   logic        w_wr_sr;
   logic        w_wr_epc;
   logic        w_unused;

   // HANDLER is consumed by the stage registers, not here.
   assign w_unused = ^{HANDLER, pc_in[1:0]};

   assign w_int_req = r_ie & ~r_exl & |(hwint & r_im);
   assign w_exc_req = ~r_exl & (exc_in != 5'd0);
   assign w_req     = ~rst & (w_int_req | w_exc_req);
   assign req       = w_req;

   assign w_code     = w_int_req ? 5'd0 : exc_in;
   assign w_epc_next = slot_in ? (pc_in[31:2] - 30'd1) : pc_in[31:2];

   assign w_wr_sr  = we & (addr == 5'd12);
   assign w_wr_epc = we & (addr == 5'd14);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_im   <= '0;
         r_exl  <= 1'b0;
         r_ie   <= 1'b0;
         r_bd   <= 1'b0;
         r_ip   <= '0;
         r_code <= '0;
         r_epc  <= '0;
      end else begin
         r_ip <= hwint;
         if (w_req) begin
            // squashed MTC0/ERET in this cycle must not take effect
            r_exl  <= 1'b1;
            r_bd   <= slot_in;
            r_code <= w_code;
            r_epc  <= w_epc_next;
         end else begin
            if (w_wr_sr) begin
               r_im  <= wdata[15:10];
               r_exl <= wdata[1];
               r_ie  <= wdata[0];
            end
            if (w_wr_epc) begin
               r_epc <= wdata[31:2];
            end
            if (eret_in) begin
               r_exl <= 1'b0;
            end
         end
      end
   end

   assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
   assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_code, 2'b00};
   assign epc_out = {r_epc, 2'b00};

   always_comb begin
      rdata = 32'd0;
      case (addr)
         5'd12:   rdata = w_sr;
         5'd13:   rdata = w_cause;
         5'd14:   rdata = {r_epc, 2'b00};
         5'd15:   rdata = PRID_VAL;
         default: rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed vector table plus randomized run against a word-level CP0 model.
// Inputs change on the falling edge; outputs are checked just after.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic [4:0]  exc_in;
   logic        slot_in;
   logic        eret_in;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [5:0]  hwint;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp0_unit dut (
      .clk    (clk),
      .rst    (rst),
      .pc_in  (pc_in),
      .exc_in (exc_in),
      .slot_in(slot_in),
      .eret_in(eret_in),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .hwint  (hwint),
      .rdata  (rdata),
      .epc_out(epc_out),
      .req    (req)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic [4:0]  exc;
      logic        slot;
      logic        eret;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [5:0]  hwint;
      logic        x_req;
      logic [31:0] x_rdata;
      logic [31:0] x_epc;
   } vec_t;

   vec_t tbl[26];

   // word-level reference state
   logic [31:0] m_sr, m_cause, m_epc;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rst     = v.rst;
      pc_in   = v.pc;
      exc_in  = v.exc;
      slot_in = v.slot;
      eret_in = v.eret;
      we      = v.we;
      addr    = v.addr;
      wdata   = v.wdata;
      hwint   = v.hwint;
   endtask

   function automatic vec_t mk(input logic r, input logic [31:0] pc,
      input logic [4:0] exc, input logic sl, input logic er,
      input logic w, input logic [4:0] a, input logic [31:0] wd,
      input logic [5:0] hw, input logic xr, input logic [31:0] xd,
      input logic [31:0] xe);
      vec_t v;
      v.rst = r; v.pc = pc; v.exc = exc; v.slot = sl; v.eret = er;
      v.we = w; v.addr = a; v.wdata = wd; v.hwint = hw;
      v.x_req = xr; v.x_rdata = xd; v.x_epc = xe;
      return v;
   endfunction

   function automatic logic m_req();
      logic exl, ie, irq;
      exl = m_sr[1];
      ie  = m_sr[0];
      irq = ie && !exl && ((hwint & m_sr[15:10]) != 6'd0);
      if (rst) return 1'b0;
      return irq || (!exl && exc_in != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd12) return m_sr;
      if (a == 5'd13) return m_cause;
      if (a == 5'd14) return m_epc;
      if (a == 5'd15) return 32'h2022_0714;
      return 32'd0;
   endfunction

   task automatic m_clock();
      logic r, irq;
      logic [31:0] target;
      r   = m_req();
      irq = m_sr[0] && !m_sr[1] && ((hwint & m_sr[15:10]) != 6'd0);
      if (rst) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else if (r) begin
         target  = slot_in ? pc_in - 32'd4 : pc_in;
         m_sr    = m_sr | 32'h2;
         m_cause = ({31'd0, slot_in} << 31) | ({26'd0, hwint} << 10)
                   | ((irq ? 32'd0 : {27'd0, exc_in}) << 2);
         m_epc   = target & ~32'h3;
      end else begin
         m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hwint} << 10);
         if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
         if (we && addr == 5'd14) m_epc = wdata & ~32'h3;
         if (eret_in) m_sr = m_sr & ~32'h2;
      end
   endtask

   initial begin
      //            rst pc          exc  sl er we addr   wdata         hw    req rdata          epc
      tbl[0]  = mk(1, 32'h0,      5'd4, 0, 0, 0, 5'd12, 32'h0,        6'h3F, 0, 32'h0,        32'h0);
      tbl[1]  = mk(1, 32'h0,      5'd4, 0, 0, 0, 5'd13, 32'h0,        6'h3F, 0, 32'h0,        32'h0);
      tbl[2]  = mk(1, 32'h0,      5'd0, 0, 0, 0, 5'd14, 32'h0,        6'h3F, 0, 32'h0,        32'h0);
      tbl[3]  = mk(0, 32'h3000,   5'd0, 0, 0, 1, 5'd12, 32'h0000_FC01, 6'h0, 0, 32'h0,        32'h0);
      tbl[4]  = mk(0, 32'h3010,   5'd0, 0, 0, 0, 5'd12, 32'h0,        6'h04, 1, 32'h0000_FC01, 32'h0);
      tbl[5]  = mk(0, 32'h3014,   5'd0, 0, 0, 0, 5'd13, 32'h0,        6'h04, 0, 32'h0000_1000, 32'h3010);
      tbl[6]  = mk(0, 32'h3018,   5'd0, 0, 0, 0, 5'd12, 32'h0,        6'h04, 0, 32'h0000_FC03, 32'h3010);
      tbl[7]  = mk(0, 32'h301C,   5'd10,0, 0, 0, 5'd13, 32'h0,        6'h04, 0, 32'h0000_1000, 32'h3010);
      tbl[8]  = mk(0, 32'h3020,   5'd0, 0, 0, 0, 5'd13, 32'h0,        6'h20, 0, 32'h0000_1000, 32'h3010);
      tbl[9]  = mk(0, 32'h3024,   5'd0, 0, 1, 0, 5'd13, 32'h0,        6'h20, 0, 32'h0000_8000, 32'h3010);
      tbl[10] = mk(0, 32'h3040,   5'd0, 0, 0, 0, 5'd12, 32'h0,        6'h20, 1, 32'h0000_FC01, 32'h3010);
      tbl[11] = mk(0, 32'h3044,   5'd0, 0, 1, 0, 5'd14, 32'h0,        6'h00, 0, 32'h0000_3040, 32'h3040);
      tbl[12] = mk(0, 32'h3048,   5'd0, 0, 0, 1, 5'd12, 32'h0000_FC00, 6'h0, 0, 32'h0000_FC01, 32'h3040);
      tbl[13] = mk(0, 32'h3024,   5'd12,1, 0, 0, 5'd12, 32'h0,        6'h01, 1, 32'h0000_FC00, 32'h3040);
      tbl[14] = mk(0, 32'h0,      5'd0, 0, 0, 0, 5'd13, 32'h0,        6'h00, 0, 32'h8000_0430, 32'h3020);
      tbl[15] = mk(0, 32'h0,      5'd0, 0, 1, 0, 5'd14, 32'h0,        6'h00, 0, 32'h0000_3020, 32'h3020);
      tbl[16] = mk(0, 32'h3050,   5'd4, 0, 0, 1, 5'd14, 32'h0000_3007, 6'h0, 1, 32'h0000_3020, 32'h3020);
      tbl[17] = mk(0, 32'h0,      5'd0, 0, 1, 0, 5'd14, 32'h0,        6'h00, 0, 32'h0000_3050, 32'h3050);
      tbl[18] = mk(0, 32'h0,      5'd0, 0, 0, 1, 5'd14, 32'h0000_3007, 6'h0, 0, 32'h0000_3050, 32'h3050);
      tbl[19] = mk(0, 32'h0,      5'd0, 0, 0, 0, 5'd14, 32'h0,        6'h00, 0, 32'h0000_3004, 32'h3004);
      tbl[20] = mk(0, 32'h0,      5'd0, 0, 0, 0, 5'd15, 32'h0,        6'h00, 0, 32'h2022_0714, 32'h3004);
      tbl[21] = mk(0, 32'h0,      5'd0, 0, 0, 1, 5'd13, 32'hFFFF_FFFF, 6'h0, 0, 32'h0000_0010, 32'h3004);
      tbl[22] = mk(0, 32'h0,      5'd0, 0, 0, 0, 5'd13, 32'h0,        6'h00, 0, 32'h0000_0010, 32'h3004);
      tbl[23] = mk(0, 32'h0,      5'd0, 0, 0, 1, 5'd7,  32'hFFFF_FFFF, 6'h0, 0, 32'h0,        32'h3004);
      tbl[24] = mk(0, 32'h0,      5'd0, 0, 0, 0, 5'd7,  32'h0,        6'h3F, 0, 32'h0,        32'h3004);
      tbl[25] = mk(0, 32'h0,      5'd0, 0, 0, 0, 5'd12, 32'h0,        6'h3F, 0, 32'h0000_FC00, 32'h3004);

      // settle registers out of X before the first checked row
      apply(tbl[0]);
      @(posedge clk);
      @(posedge clk);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         #1;
         chk($sformatf("vec%0d req", i), {31'd0, req}, {31'd0, tbl[i].x_req});
         chk($sformatf("vec%0d rdata", i), rdata, tbl[i].x_rdata);
         chk($sformatf("vec%0d epc", i), epc_out, tbl[i].x_epc);
      end

      // randomized phase, starting from a reset the model also sees
      @(negedge clk);
      apply(tbl[0]);
      m_clock();
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] r;
         @(negedge clk);
         r       = $urandom;
         rst     = ($urandom_range(0, 99) == 0);
         pc_in   = {16'd0, 14'($urandom), 2'b00};
         exc_in  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         slot_in = r[0];
         hwint   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         eret_in = ($urandom_range(0, 9) == 0);
         we      = !eret_in && ($urandom_range(0, 3) == 0);
         case (r[3:1])
            3'd0, 3'd1: addr = 5'd12;
            3'd2:       addr = 5'd13;
            3'd3, 3'd4: addr = 5'd14;
            3'd5:       addr = 5'd15;
            default:    addr = 5'($urandom);
         endcase
         wdata   = $urandom;
         #1;
         chk("rnd req", {31'd0, req}, {31'd0, m_req()});
         chk("rnd rdata", rdata, m_read(addr));
         chk("rnd epc", epc_out, m_epc);
         m_clock();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
